// File: rtl/tm1638_responder_pkg.sv
// Shared definitions for the TM1638 responder.
// Contents: command opcode field values, data/control command bit positions,
// FSM state encoding and a small opcode helper.
package tm1638_responder_pkg;

  // Top two bits of the first byte of a frame select the command class.
  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_CTRL = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  // Bit positions inside data and display-control commands.
  localparam int DATA_RD_BIT  = 1;  // 1 = key read, 0 = display write
  localparam int DATA_FIX_BIT = 2;  // 1 = fixed address, 0 = auto-increment
  localparam int CTRL_ON_BIT  = 3;  // display enable

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_RDATA,
    S_IGNORE
  } state_e;

  function automatic logic [1:0] cmd_opcode(input logic [7:0] b);
    return b[7:6];
  endfunction

endpackage

// File: rtl/tm1638_responder_bus_sync.sv
// Bus synchroniser for the TM1638 responder.
// Brings stb/sclk/dio_in into the clk domain through SYNC_STAGES flops and
// produces single-cycle rise/fall strobes for stb and sclk.
// Ports:
//   clk                     system clock
//   stb, sclk, dio_in       asynchronous bus pins
//   stb_rise, stb_fall      1-cycle strobes on synchronised stb edges
//   sclk_rise, sclk_fall    1-cycle strobes on synchronised sclk edges
//   dio_s                   synchronised dio, aligned with the sclk strobes
// The chains carry no reset on purpose: after a mid-frame reset a still-low
// stb must not look like a fresh falling edge.
module tm1638_responder_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic stb,
  input  logic sclk,
  input  logic dio_in,
  output logic stb_rise,
  output logic stb_fall,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic dio_s
);

  logic [SYNC_STAGES-1:0] stb_q;
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] dio_q;
  logic                   stb_prev_q;
  logic                   sclk_prev_q;

  always_ff @(posedge clk) begin
    stb_q       <= {stb_q[SYNC_STAGES-2:0], stb};
    sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk};
    dio_q       <= {dio_q[SYNC_STAGES-2:0], dio_in};
    stb_prev_q  <= stb_q[SYNC_STAGES-1];
    sclk_prev_q <= sclk_q[SYNC_STAGES-1];
  end

  assign stb_rise  =  stb_q[SYNC_STAGES-1]  & ~stb_prev_q;
  assign stb_fall  = ~stb_q[SYNC_STAGES-1]  &  stb_prev_q;
  assign sclk_rise =  sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] &  sclk_prev_q;
  assign dio_s     =  dio_q[SYNC_STAGES-1];

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device-side responder.
// Decodes data, display-control and address commands from an external
// master, stores written bytes in a 16x8 display RAM and shifts a 32-bit
// key word back during read frames.
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   stb, sclk, dio_in     bus inputs from the master
//   dio_out, dio_oe       bus data back to the master and its enable
//   keys                  key-scan word, bit0 sent first
//   ram_raddr, ram_rdata  host read port into display RAM (1-cycle latency)
//   disp_on, brightness   last display-control settings
//   byte_stb              pulse per completed byte
//   frame_err             pulse when a frame ends on a partial byte
module tm1638_responder
  import tm1638_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        sclk,
  input  logic        dio_in,
  output logic        dio_out,
  output logic        dio_oe,
  input  logic [31:0] keys,
  input  logic [3:0]  ram_raddr,
  output logic [7:0]  ram_rdata,
  output logic        disp_on,
  output logic [2:0]  brightness,
  output logic        byte_stb,
  output logic        frame_err
);

  logic stb_rise, stb_fall, sclk_rise, sclk_fall, dio_s;

  tm1638_responder_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .stb       (stb),
    .sclk      (sclk),
    .dio_in    (dio_in),
    .stb_rise  (stb_rise),
    .stb_fall  (stb_fall),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .dio_s     (dio_s)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_ctr_q, bit_ctr_d;
  logic [7:0]  shift_q, shift_d;
  logic [31:0] key_q, key_d;
  logic [3:0]  addr_q, addr_d;
  logic        fixed_q, fixed_d;
  logic        disp_on_q, disp_on_d;
  logic [2:0]  bright_q, bright_d;
  logic        dio_out_q, dio_out_d;
  logic        dio_oe_q, dio_oe_d;
  logic        byte_stb_q, byte_stb_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  ram_q [16];
  logic [7:0]  ram_rdata_q;
  logic        ram_we;
  logic [7:0]  rx_byte;

  // Byte as it stands once the current rising edge has been shifted in.
  assign rx_byte = {dio_s, shift_q[7:1]};

  always_comb begin
    state_d     = state_q;
    bit_ctr_d   = bit_ctr_q;
    shift_d     = shift_q;
    key_d       = key_q;
    addr_d      = addr_q;
    fixed_d     = fixed_q;
    disp_on_d   = disp_on_q;
    bright_d    = bright_q;
    dio_out_d   = dio_out_q;
    dio_oe_d    = dio_oe_q;
    byte_stb_d  = 1'b0;
    frame_err_d = 1'b0;
    ram_we      = 1'b0;

    if (state_q == S_IDLE) begin
      // Bus clock edges outside a frame are ignored.
      if (stb_fall) begin
        state_d   = S_CMD;
        bit_ctr_d = 3'd0;
      end
    end else if (stb_rise) begin
      // End of frame wins over any same-cycle clock edge; a partial byte is dropped.
      state_d     = S_IDLE;
      bit_ctr_d   = 3'd0;
      dio_oe_d    = 1'b0;
      dio_out_d   = 1'b0;
      frame_err_d = (bit_ctr_q != 3'd0);
    end else begin
      if (state_q == S_RDATA && sclk_fall) dio_out_d = key_q[0];

      if (sclk_rise) begin
        shift_d   = rx_byte;
        bit_ctr_d = bit_ctr_q + 3'd1;
        if (state_q == S_RDATA) key_d = {1'b0, key_q[31:1]};

        if (bit_ctr_q == 3'd7) begin
          byte_stb_d = 1'b1;
          case (state_q)
            S_CMD: begin
              case (cmd_opcode(rx_byte))
                CMD_DATA: begin
                  if (rx_byte[DATA_RD_BIT]) begin
                    state_d  = S_RDATA;
                    key_d    = keys;
                    dio_oe_d = 1'b1;
                  end else begin
                    // Only write commands change the addressing mode, so it
                    // survives intervening read frames.
                    fixed_d = rx_byte[DATA_FIX_BIT];
                    state_d = S_IGNORE;
                  end
                end
                CMD_CTRL: begin
                  disp_on_d = rx_byte[CTRL_ON_BIT];
                  bright_d  = rx_byte[2:0];
                  state_d   = S_IGNORE;
                end
                CMD_ADDR: begin
                  addr_d  = rx_byte[3:0];
                  state_d = S_WDATA;
                end
                default: state_d = S_IGNORE;
              endcase
            end
            S_WDATA: begin
              ram_we = 1'b1;
              if (!fixed_q) addr_d = addr_q + 4'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_ctr_q   <= 3'd0;
      shift_q     <= 8'h00;
      key_q       <= 32'h0;
      addr_q      <= 4'd0;
      fixed_q     <= 1'b0;
      disp_on_q   <= 1'b0;
      bright_q    <= 3'd0;
      dio_out_q   <= 1'b0;
      dio_oe_q    <= 1'b0;
      byte_stb_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_ctr_q   <= bit_ctr_d;
      shift_q     <= shift_d;
      key_q       <= key_d;
      addr_q      <= addr_d;
      fixed_q     <= fixed_d;
      disp_on_q   <= disp_on_d;
      bright_q    <= bright_d;
      dio_out_q   <= dio_out_d;
      dio_oe_q    <= dio_oe_d;
      byte_stb_q  <= byte_stb_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Display RAM is cleared by reset, so it is built from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) ram_q[i] <= 8'h00;
      ram_rdata_q <= 8'h00;
    end else begin
      if (ram_we) ram_q[addr_q] <= rx_byte;
      ram_rdata_q <= ram_q[ram_raddr];
    end
  end

  assign dio_out    = dio_out_q;
  assign dio_oe     = dio_oe_q;
  assign disp_on    = disp_on_q;
  assign brightness = bright_q;
  assign byte_stb   = byte_stb_q;
  assign frame_err  = frame_err_q;
  assign ram_rdata  = ram_rdata_q;

endmodule

// File: tb/tb_tm1638_responder.sv
module tb_tm1638_responder;

  localparam int HALF = 6;  // bus half-period in system clocks

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b1;
  logic        sclk = 1'b1;
  logic        dio_in = 1'b0;
  logic        dio_out, dio_oe;
  logic [31:0] keys = 32'h0;
  logic [3:0]  ram_raddr = 4'd0;
  logic [7:0]  ram_rdata;
  logic        disp_on;
  logic [2:0]  brightness;
  logic        byte_stb, frame_err;

  int passed = 0;
  int total  = 0;
  int bstb_cnt = 0;
  int ferr_cnt = 0;

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stb        (stb),
    .sclk       (sclk),
    .dio_in     (dio_in),
    .dio_out    (dio_out),
    .dio_oe     (dio_oe),
    .keys       (keys),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .disp_on    (disp_on),
    .brightness (brightness),
    .byte_stb   (byte_stb),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (byte_stb === 1'b1)  bstb_cnt <= bstb_cnt + 1;
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  typedef struct {
    logic [31:0] bytes;     // byte k in bits [8k+7:8k], sent first to last
    int          n;
    logic [3:0]  raddr;
    logic [7:0]  exp_ram;
    logic        exp_on;
    logic [2:0]  exp_br;
    int          exp_bstb;
  } vec_t;

  vec_t vecs [16];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0; dio_in = b[i];
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic read_byte(output logic [7:0] b, output logic oe_low);
    oe_low = 1'b0;
    b = 8'h00;
    dio_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0;
      tick(HALF);
      sclk = 1'b1;
      b[i] = dio_out;
      if (dio_oe !== 1'b1) oe_low = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic send_frame(input logic [31:0] bytes, input int n);
    logic [31:0] bb;
    bb = bytes;
    stb = 1'b0;
    tick(HALF);
    for (int k = 0; k < n; k++) begin
      send_byte(bb[7:0]);
      bb = bb >> 8;
    end
    tick(HALF);
    stb = 1'b1;
    tick(3 * HALF);
  endtask

  task automatic ram_read(input logic [3:0] a, output logic [7:0] d);
    ram_raddr = a;
    tick(2);
    d = ram_rdata;
  endtask

  initial begin
    logic [7:0] rd;
    logic       oe_low, oe_any_low;
    int         b0, f0;
    logic [7:0] exp_keys [5];

    vecs[0]  = '{32'h0000_0040,    1, 4'd0,  8'h00, 1'b0, 3'd0, 1};
    vecs[1]  = '{32'h3322_11C0,    4, 4'd0,  8'h11, 1'b0, 3'd0, 4};
    vecs[2]  = '{32'h0000_008D,    1, 4'd1,  8'h22, 1'b1, 3'd5, 1};
    vecs[3]  = '{32'h0000_0044,    1, 4'd2,  8'h33, 1'b1, 3'd5, 1};
    vecs[4]  = '{32'h00BB_AAC5,    3, 4'd5,  8'hBB, 1'b1, 3'd5, 3};
    vecs[5]  = '{32'h0000_008A,    1, 4'd6,  8'h00, 1'b1, 3'd2, 1};
    vecs[6]  = '{32'h0000_0040,    1, 4'd5,  8'hBB, 1'b1, 3'd2, 1};
    vecs[7]  = '{32'h0002_01CF,    3, 4'd15, 8'h01, 1'b1, 3'd2, 3};
    vecs[8]  = '{32'h0000_0080,    1, 4'd0,  8'h02, 1'b0, 3'd0, 1};
    vecs[9]  = '{32'h0000_0000,    1, 4'd1,  8'h22, 1'b0, 3'd0, 1};
    vecs[10] = '{32'h0000_0044,    1, 4'd1,  8'h22, 1'b0, 3'd0, 1};
    vecs[11] = '{32'h0077_66C8,    3, 4'd8,  8'h77, 1'b0, 3'd0, 3};
    vecs[12] = '{32'h0034_12CA,    3, 4'd10, 8'h34, 1'b0, 3'd0, 3};
    vecs[13] = '{32'h0000_008F,    1, 4'd11, 8'h00, 1'b1, 3'd7, 1};
    vecs[14] = '{32'h0000_0040,    1, 4'd9,  8'h00, 1'b1, 3'd7, 1};
    vecs[15] = '{32'h006B_5AC3,    3, 4'd4,  8'h6B, 1'b1, 3'd7, 3};

    // Reset state
    tick(10);
    rst_n = 1'b1;
    tick(1);
    check("rst_dio_out",    {31'h0, dio_out},       32'h0);
    check("rst_dio_oe",     {31'h0, dio_oe},        32'h0);
    check("rst_disp_on",    {31'h0, disp_on},       32'h0);
    check("rst_brightness", {29'h0, brightness},    32'h0);
    check("rst_byte_stb",   {31'h0, byte_stb},      32'h0);
    check("rst_frame_err",  {31'h0, frame_err},     32'h0);
    check("rst_ram_rdata",  {24'h0, ram_rdata},     32'h0);
    ram_read(4'd15, rd);
    check("rst_ram15", {24'h0, rd}, 32'h0);

    // Table-driven frames
    for (int v = 0; v < 16; v++) begin
      b0 = bstb_cnt;
      send_frame(vecs[v].bytes, vecs[v].n);
      ram_read(vecs[v].raddr, rd);
      check($sformatf("v%0d_ram%0d", v, vecs[v].raddr), {24'h0, rd}, {24'h0, vecs[v].exp_ram});
      check($sformatf("v%0d_disp_on", v), {31'h0, disp_on}, {31'h0, vecs[v].exp_on});
      check($sformatf("v%0d_brightness", v), {29'h0, brightness}, {29'h0, vecs[v].exp_br});
      check($sformatf("v%0d_byte_stb_count", v), bstb_cnt - b0, vecs[v].exp_bstb);
    end
    ram_read(4'd3, rd);
    check("ram3_after_autoinc", {24'h0, rd}, 32'h5A);

    // Key read frame: 4 key bytes LSB first, then zeros once exhausted
    keys = 32'hA5C3_0F81;
    exp_keys[0] = 8'h81; exp_keys[1] = 8'h0F; exp_keys[2] = 8'hC3;
    exp_keys[3] = 8'hA5; exp_keys[4] = 8'h00;
    check("pre_read_dio_oe", {31'h0, dio_oe}, 32'h0);
    stb = 1'b0;
    tick(HALF);
    send_byte(8'h42);
    oe_any_low = 1'b0;
    for (int k = 0; k < 5; k++) begin
      read_byte(rd, oe_low);
      if (oe_low) oe_any_low = 1'b1;
      check($sformatf("key_byte%0d", k), {24'h0, rd}, {24'h0, exp_keys[k]});
    end
    check("read_dio_oe_held", {31'h0, oe_any_low}, 32'h0);
    tick(HALF);
    stb = 1'b1;
    tick(3 * HALF);
    check("post_read_dio_oe", {31'h0, dio_oe}, 32'h0);
    check("post_read_dio_out", {31'h0, dio_out}, 32'h0);
    dio_in = 1'b0;
    // Read mode must not linger; auto-increment write mode still in force.
    send_frame(32'h0000_3CC4, 2);
    ram_read(4'd4, rd);
    check("write_after_read_ram4", {24'h0, rd}, 32'h3C);

    // Partial byte at end of frame
    b0 = bstb_cnt; f0 = ferr_cnt;
    stb = 1'b0;
    tick(HALF);
    send_byte(8'hC2);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b0; dio_in = 1'b1; tick(HALF);
      sclk = 1'b1; tick(HALF);
    end
    stb = 1'b1;
    tick(3 * HALF);
    check("partial_frame_err_count", ferr_cnt - f0, 1);
    check("partial_byte_stb_count", bstb_cnt - b0, 1);
    ram_read(4'd2, rd);
    check("partial_ram2_unchanged", {24'h0, rd}, 32'h33);
    f0 = ferr_cnt;
    send_frame(32'h0000_55C2, 2);
    ram_read(4'd2, rd);
    check("after_partial_ram2", {24'h0, rd}, 32'h55);
    check("after_partial_no_err", ferr_cnt - f0, 0);

    // Reset in the middle of a write frame
    f0 = ferr_cnt;
    stb = 1'b0;
    tick(HALF);
    send_byte(8'hC0);
    send_byte(8'h77);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("midrst_disp_on", {31'h0, disp_on}, 32'h0);
    check("midrst_brightness", {29'h0, brightness}, 32'h0);
    check("midrst_dio_oe", {31'h0, dio_oe}, 32'h0);
    b0 = bstb_cnt;
    send_byte(8'h88);
    send_byte(8'h99);
    tick(HALF);
    stb = 1'b1;
    tick(3 * HALF);
    check("midrst_byte_stb_ignored", bstb_cnt - b0, 0);
    check("midrst_no_frame_err", ferr_cnt - f0, 0);
    ram_read(4'd0, rd);
    check("midrst_ram0", {24'h0, rd}, 32'h0);
    ram_read(4'd1, rd);
    check("midrst_ram1", {24'h0, rd}, 32'h0);
    ram_read(4'd15, rd);
    check("midrst_ram15", {24'h0, rd}, 32'h0);
    send_frame(32'h0000_42C1, 2);
    ram_read(4'd1, rd);
    check("recover_ram1", {24'h0, rd}, 32'h42);
    ram_read(4'd0, rd);
    check("recover_ram0", {24'h0, rd}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
